// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared Hamming(15,11) constants, types and pure encoder
package hamming_pkg;

   localparam int DATA_W = 11;
   localparam int CODE_W = 15;
   localparam int PAR_W  = 4;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [CODE_W-1:0] code_t;
   typedef logic [PAR_W-1:0]  syndrome_t;

   // codeword bit index of the parity bits at positions 1, 2, 4, 8
   localparam int P1_BIT = 0;
   localparam int P2_BIT = 1;
   localparam int P4_BIT = 3;
   localparam int P8_BIT = 7;

   // data bits d[i] whose codeword position has the matching parity bit set
   localparam data_t P1_MASK = 11'h55B;
   localparam data_t P2_MASK = 11'h66D;
   localparam data_t P4_MASK = 11'h78E;
   localparam data_t P8_MASK = 11'h7F0;

   function automatic code_t hamming_encode(input data_t d);
      code_t c;
      c = {d[10:4], 1'b0, d[3:1], 1'b0, d[0], 2'b00};
      c[P1_BIT] = ^(d & P1_MASK);
      c[P2_BIT] = ^(d & P2_MASK);
      c[P4_BIT] = ^(d & P4_MASK);
      c[P8_BIT] = ^(d & P8_MASK);
      return c;
   endfunction

endpackage

// File: rtl/hamming_fifo.sv
// rtl/hamming_fifo.sv - DEPTH x WIDTH synchronous FIFO with count, full and empty
module hamming_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 15,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic [AW:0]      count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      count_q, count_d;
   logic             wr, rd;

   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign wr        = wr_en_i && !full_o;
   assign rd        = rd_en_i && !empty_o;
   assign rd_data_o = mem_q[rptr_q];
   assign count_o   = count_q;

   always_comb begin
      count_d = count_q;
      case ({wr, rd})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (wr) begin
            mem_q[wptr_q] <= wr_data_i;
            wptr_q        <= wptr_q + AW'(1);
         end
         if (rd) rptr_q <= rptr_q + AW'(1);
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/hamming_enc_stream.sv
// rtl/hamming_enc_stream.sv - streaming Hamming(15,11) encoder; HAMMING_ERR_INJ_EN adds error injection
module hamming_enc_stream
   import hamming_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef HAMMING_ERR_INJ_EN
   input  logic              inj_en,
   input  logic [3:0]        inj_pos,
   output logic [CNT_W-1:0]  err_cnt,
`endif
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [CODE_W-1:0] out_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  word_cnt
);

   localparam int AW = $clog2(DEPTH);

   code_t            enc_code, wr_code;
   logic             accept, pop, fifo_full, fifo_empty;
   logic [AW:0]      fifo_count;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

   assign enc_code  = hamming_encode(in_data);
   assign in_ready  = (fifo_count < (AW+1)'(DEPTH));
   assign out_valid = !fifo_empty;
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

`ifdef HAMMING_ERR_INJ_EN
   logic             inj_hit;
   code_t            flip_mask;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   assign inj_hit   = inj_en && (inj_pos != 4'd0);
   assign flip_mask = inj_hit ? code_t'(15'd1 << (inj_pos - 4'd1)) : '0;
   assign wr_code   = enc_code ^ flip_mask;
   assign err_cnt_d = (accept && inj_hit) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
   assign err_cnt   = err_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_cnt_q <= '0;
      else        err_cnt_q <= err_cnt_d;
   end
`else
   assign wr_code = enc_code;
`endif

   assign word_cnt_d = pop ? word_cnt_q + CNT_W'(1) : word_cnt_q;
   assign word_cnt   = word_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) word_cnt_q <= '0;
      else        word_cnt_q <= word_cnt_d;
   end

   hamming_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CODE_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (in_valid && !fifo_full),
      .wr_data_i (wr_code),
      .rd_en_i   (pop),
      .rd_data_o (out_code),
      .count_o   (fifo_count),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

endmodule

// File: tb/tb_hamming_enc_stream.sv
// tb/tb_hamming_enc_stream.sv - randomized scoreboard bench for hamming_enc_stream
module tb_hamming_enc_stream;

   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [10:0]      in_data = '0;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic             in_ready, out_valid;
   logic [14:0]      out_code;
   logic [CNT_W-1:0] word_cnt;
`ifdef HAMMING_ERR_INJ_EN
   logic             inj_en = 1'b0;
   logic [3:0]       inj_pos = '0;
   logic [CNT_W-1:0] err_cnt;
   int unsigned      m_err = 0;
`endif

   int          total = 0;
   int          bad = 0;
   int unsigned m_words = 0;
   logic [14:0] q_code[$];
   logic [10:0] q_data[$];

   always #5 clk = ~clk;

   hamming_enc_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef HAMMING_ERR_INJ_EN
      .inj_en    (inj_en),
      .inj_pos   (inj_pos),
      .err_cnt   (err_cnt),
`endif
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_code  (out_code),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .word_cnt  (word_cnt)
   );

   function automatic logic [14:0] ref_encode(input logic [10:0] d);
      logic [14:0] c;
      logic        par;
      int          j;
      c = '0;
      j = 0;
      for (int p = 1; p <= 15; p++)
         if ((p & (p - 1)) != 0) begin
            if (((d >> j) & 11'd1) != 0) c = c | (15'd1 << (p - 1));
            j++;
         end
      for (int k = 0; k < 4; k++) begin
         par = 1'b0;
         for (int p = 1; p <= 15; p++)
            if (((p >> k) & 1) != 0 && ((c >> (p - 1)) & 15'd1) != 0) par = ~par;
         if (par) c = c | (15'd1 << ((1 << k) - 1));
      end
      return c;
   endfunction

   function automatic logic [10:0] ref_decode(input logic [14:0] c_in);
      logic [14:0] c;
      logic [10:0] d;
      int          syn, j;
      c = c_in;
      syn = 0;
      for (int p = 1; p <= 15; p++)
         if (((c >> (p - 1)) & 15'd1) != 0) syn = syn ^ p;
      if (syn != 0) c = c ^ (15'd1 << (syn - 1));
      d = '0;
      j = 0;
      for (int p = 1; p <= 15; p++)
         if ((p & (p - 1)) != 0) begin
            if (((c >> (p - 1)) & 15'd1) != 0) d = d | (11'd1 << j);
            j++;
         end
      return d;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // scoreboard: checks DUT against the queue model, then applies the coming edge
   always @(negedge clk) begin
      logic        acc;
      logic [14:0] c;
      if (!rst_n) begin
         q_code.delete();
         q_data.delete();
         m_words = 0;
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 1);
         chk("rst_word_cnt", word_cnt, 0);
         chk("rst_out_code", out_code, 0);
`ifdef HAMMING_ERR_INJ_EN
         m_err = 0;
         chk("rst_err_cnt", err_cnt, 0);
`endif
      end else begin
         chk("in_ready", in_ready, q_code.size() < DEPTH);
         chk("out_valid", out_valid, q_code.size() != 0);
         chk("word_cnt", word_cnt, m_words & 32'hFFFF);
`ifdef HAMMING_ERR_INJ_EN
         chk("err_cnt", err_cnt, m_err & 32'hFFFF);
`endif
         if (q_code.size() != 0) chk("out_code", out_code, q_code[0]);
         acc = in_valid && (q_code.size() < DEPTH);
         if (out_ready && q_code.size() != 0) begin
            chk("decode", ref_decode(out_code), q_data[0]);
            void'(q_code.pop_front());
            void'(q_data.pop_front());
            m_words++;
         end
         if (acc) begin
            c = ref_encode(in_data);
`ifdef HAMMING_ERR_INJ_EN
            if (inj_en && inj_pos != 0) begin
               c = c ^ (15'd1 << (inj_pos - 1));
               m_err++;
            end
`endif
            q_code.push_back(c);
            q_data.push_back(in_data);
         end
      end
   end

   initial begin
      logic [10:0] dv[3];
      logic [14:0] cv[3];
      dv = '{11'h000, 11'h001, 11'h7FF};
      cv = '{15'h0000, 15'h0007, 15'h7FFF};

      tick();
      tick();
      rst_n = 1'b1;

      for (int i = 0; i < 3; i++) chk("model_enc", ref_encode(dv[i]), cv[i]);
      chk("model_dec", ref_decode(15'h0017), 11'h001);

      // directed literals, one word at a time
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = dv[i];
         in_valid = 1'b1;
         #1 chk("no_bypass", out_valid, 0);
         tick();
         in_valid = 1'b0;
         chk("lat_valid", out_valid, 1);
         chk("lat_code", out_code, cv[i]);
         tick();
         chk("pop_word_cnt", word_cnt, i + 1);
      end

      // fill to full with downstream stalled, hold a 5th word
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_data = 11'($urandom);
         in_valid = 1'b1;
         tick();
      end
      chk("full_in_ready", in_ready, 0);
      in_data = 11'($urandom);
      repeat (3) tick();
      chk("held_in_ready", in_ready, 0);
      chk("held_word_cnt", word_cnt, 3);
      out_ready = 1'b1;
      tick();
      chk("ready_after_pop", in_ready, 1);
      tick();
      in_valid = 1'b0;
      repeat (6) tick();
      chk("drain_word_cnt", word_cnt, 8);

      // asynchronous reset with 3 words buffered
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_data = 11'($urandom);
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      chk("pre_rst_valid", out_valid, 1);
      #1 rst_n = 1'b0;
      #1 chk("async_out_valid", out_valid, 0);
      chk("async_in_ready", in_ready, 1);
      tick();
      chk("rst_edge_word_cnt", word_cnt, 0);
      chk("rst_edge_valid", out_valid, 0);
      rst_n = 1'b1;

      // back-to-back stream of 20 words
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = 11'($urandom);
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("stream_word_cnt", word_cnt, 20);

`ifdef HAMMING_ERR_INJ_EN
      do_reset();
      out_ready = 1'b0;
      in_data = 11'h001;
      inj_en = 1'b1;
      inj_pos = 4'd5;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      inj_en = 1'b0;
      inj_pos = 4'd0;
      chk("inj_code", out_code, 15'h0017);
      chk("inj_err_cnt", err_cnt, 1);
      chk("inj_corrected", ref_encode(ref_decode(out_code)), 15'h0007);
      out_ready = 1'b1;
      tick();
`endif

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         in_data = 11'($urandom);
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
`ifdef HAMMING_ERR_INJ_EN
         inj_en = ($urandom_range(0, 3) == 0);
         inj_pos = 4'($urandom);
`endif
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (DEPTH + 2) tick();
      chk("final_empty", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
